dot_vector_loader: RTL

//  Host-side feeder for the byte-serial dot-product/max engine. Accepts one 32-bit weight

---
 rtl/dot_vector_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dot_vector_loader.sv
// dot_vector_loader: host-side feeder for the byte-serial dot-product/max engine.
// Serialises a captured weight/input vector pair onto byte_out/sel_out, LSB lane
// first, and in idle recirculates the stored input lanes so the engine's input
// register keeps holding the vector. aligned marks the cycle after the engine
// has shifted in input lane BYTES-1. Requires BYTES >= 2.
//
// Handshake: a vector transfers on a rising edge where vec_valid && vec_ready.
// vec_ready is high exactly while the FSM is IDLE; vec_valid seen while busy is
// ignored, and a valid held across a load is taken at the first IDLE edge.
module dot_vector_loader #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,        // synchronous, active-high despite the name
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [8*BYTES-1:0] vec_weights,
  input  logic [8*BYTES-1:0] vec_inputs,
  input  logic               upd_weights,
  output logic [7:0]         byte_out,
  output logic               sel_out,
  output logic               aligned,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int IW = $clog2(BYTES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_I = 2'd2
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       phase_q;
  logic [8*BYTES-1:0]  w_q;
  logic [8*BYTES-1:0]  i_q;
  logic [7:0]          byte_q;
  logic                sel_q;
  logic                aligned_q;
  logic                cur_last_q;  // byte_q currently holds input lane BYTES-1
  logic                loaded_q;    // a complete vector has reached the engine since reset

  logic [7:0]          w_idx_lane;
  logic [7:0]          i_idx_lane;
  logic [7:0]          i_phase_lane;
  logic [IW-1:0]       phase_d;

  // Lane selection from the stored vectors for the load counter and the idle phase.
  always_comb begin
    w_idx_lane   = w_q[8*int'(idx_q) +: 8];
    i_idx_lane   = i_q[8*int'(idx_q) +: 8];
    i_phase_lane = i_q[8*int'(phase_q) +: 8];
    phase_d      = (phase_q == LAST) ? '0 : phase_q + 1'b1;
  end

  // Single FSM: accept, serialise weights then inputs, recirculate inputs in idle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      phase_q    <= '0;
      w_q        <= '0;
      i_q        <= '0;
      byte_q     <= '0;
      sel_q      <= 1'b0;
      aligned_q  <= 1'b0;
      cur_last_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      // The engine samples the current byte at this edge; if it is input lane
      // BYTES-1 of a completed vector, the engine register is now exact.
      aligned_q <= cur_last_q && loaded_q;
      unique case (state_q)
        IDLE: begin
          if (vec_valid) begin
            w_q        <= vec_weights;
            i_q        <= vec_inputs;
            idx_q      <= IW'(1);
            cur_last_q <= 1'b0;
            if (upd_weights) begin
              state_q <= LOAD_W;
              byte_q  <= vec_weights[7:0];
              sel_q   <= 1'b1;
            end else begin
              state_q <= LOAD_I;
              byte_q  <= vec_inputs[7:0];
              sel_q   <= 1'b0;
            end
          end else begin
            byte_q     <= i_phase_lane;
            sel_q      <= 1'b0;
            cur_last_q <= (phase_q == LAST);
            phase_q    <= phase_d;
          end
        end
        LOAD_W: begin
          byte_q     <= w_idx_lane;
          sel_q      <= 1'b1;
          cur_last_q <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= LOAD_I;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        LOAD_I: begin
          byte_q     <= i_idx_lane;
          sel_q      <= 1'b0;
          cur_last_q <= (idx_q == LAST);
          if (idx_q == LAST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= '0;
            loaded_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec_ready = (state_q == IDLE);
  assign busy      = ~vec_ready;
  assign byte_out  = byte_q;
  assign sel_out   = sel_q;
  assign aligned   = aligned_q;
  assign dbg_state = state_q;

endmodule
